// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 core pipeline registers.
// Imported by pipe_stage_reg and pipe_skid_buf.
package cpu_pkg;

  localparam int PIPE_MAX_DEPTH = 8;

  // Replicated to CTRL_W; an all-zero control word is a NOP.
  localparam logic PIPE_CTRL_NOP = 1'b0;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 8;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_CTRL_W-1:0] ctrl;
  } pipe_beat_t;

  function automatic pipe_beat_t pipe_beat(
    input logic [PIPE_DATA_W-1:0] data,
    input logic [PIPE_CTRL_W-1:0] ctrl
  );
    pipe_beat_t b;
    b.data = data;
    b.ctrl = ctrl;
    return b;
  endfunction

  function automatic int pipe_occ_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat bus between pipeline stages.
// master drives the beat, slave drives ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer in front of slice 0 of pipe_stage_reg.
// in_ready comes from the skid flop, cutting the downstream ready path.
module pipe_skid_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              sk_v;
  logic [DATA_W-1:0] sk_d;
  logic [CTRL_W-1:0] sk_c;
  logic              acc;

  assign in_ready  = reset_n & ~sk_v & ~stall;
  assign acc       = in_valid & in_ready;

  // A parked beat always goes first.
  assign out_valid = sk_v | acc;
  assign out_data  = sk_v ? sk_d : in_data;
  assign out_ctrl  = sk_v ? sk_c : in_ctrl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sk_v <= 1'b0;
      sk_d <= '0;
      sk_c <= '0;
    end else if (flush) begin
      sk_v <= 1'b0;
      sk_c <= {CTRL_W{PIPE_CTRL_NOP}};
    end else if (sk_v && out_ready) begin
      sk_v <= 1'b0;
      sk_c <= {CTRL_W{PIPE_CTRL_NOP}};
    end else if (acc && !out_ready) begin
      sk_v <= 1'b1;
      sk_d <= in_data;
      sk_c <= in_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised DEPTH-slice pipeline register with stall/flush/bubble collapse.
// Optional skid entry in front of slice 0 when PIPE_SKID_EN is defined.
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int OCC_W  = $clog2(DEPTH + 2)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  pipe_stage_reg_if.slave  src,
  pipe_stage_reg_if.master dst,
  output logic [OCC_W-1:0] occupancy
);

`ifdef PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  localparam int OCC_MAX = DEPTH + SKID;

  logic [DEPTH-1:0]  v_q;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [CTRL_W-1:0] c_q [DEPTH];
  logic [DEPTH:0]    rdy;
  logic              head_v;
  logic [DATA_W-1:0] head_d;
  logic [CTRL_W-1:0] head_c;
  logic              acc;
  logic              emit;
  logic [OCC_W-1:0]  occ_q;

  // rdy[k]: slice k may load this cycle.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = dst.ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~stall & (~v_q[k] | rdy[k+1]);
    end
  end

`ifdef PIPE_SKID_EN
  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (src.valid),
    .in_ready  (src.ready),
    .in_data   (src.data),
    .in_ctrl   (src.ctrl),
    .out_valid (head_v),
    .out_ready (rdy[0]),
    .out_data  (head_d),
    .out_ctrl  (head_c)
  );
`else
  assign src.ready = reset_n & rdy[0];
  assign head_v    = src.valid;
  assign head_d    = src.data;
  assign head_c    = src.ctrl;
`endif

  assign acc  = src.valid & src.ready;
  assign emit = v_q[DEPTH-1] & dst.ready & ~stall;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    logic              nv;
    logic [DATA_W-1:0] nd;
    logic [CTRL_W-1:0] nc;
    logic              v_r;
    logic [DATA_W-1:0] d_r;
    logic [CTRL_W-1:0] c_r;

    if (k == 0) begin : g_head
      assign nv = head_v;
      assign nd = head_d;
      assign nc = head_c;
    end else begin : g_mid
      assign nv = v_q[k-1];
      assign nd = d_q[k-1];
      assign nc = c_q[k-1];
    end

    // Bubbles zero ctrl but leave data as it was.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v_r <= 1'b0;
        d_r <= '0;
        c_r <= '0;
      end else if (flush) begin
        v_r <= 1'b0;
        c_r <= {CTRL_W{PIPE_CTRL_NOP}};
      end else if (rdy[k]) begin
        v_r <= nv;
        c_r <= nv ? nc : {CTRL_W{PIPE_CTRL_NOP}};
        if (nv) d_r <= nd;
      end
    end

    assign v_q[k] = v_r;
    assign d_q[k] = d_r;
    assign c_q[k] = c_r;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      unique case ({acc, emit})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy = occ_q;
  assign dst.valid = v_q[DEPTH-1];
  assign dst.data  = d_q[DEPTH-1];
  assign dst.ctrl  = v_q[DEPTH-1] ? c_q[DEPTH-1]
                                  : {CTRL_W{PIPE_CTRL_NOP}};

  a_occ_max: assert property (
    @(posedge clock) disable iff (!reset_n)
    int'(occupancy) <= OCC_MAX
  );

endmodule
